// File: rtl/w5300_bus_responder.sv
// w5300_bus_responder: responder model of the W5300 16-bit direct-mode host bus.
// Common register file, socket-0 registers, socket-0 TX/RX FIFOs and command FSM.
// Optional feature: define W5300_RESP_PROTO_CHECK_EN to build the sticky proto_err checker;
// when undefined proto_err is tied low.
module w5300_bus_responder #(
  parameter logic [7:0]  CLK_FREQ      = 8'd100,
  parameter int unsigned RX_FIFO_DEPTH = 64,
  parameter int unsigned TX_FIFO_DEPTH = 64,
  parameter logic [15:0] CHIP_ID       = 16'h5300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        w_rst_n,
  input  logic        cs_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [9:0]  addr,
  inout  tri   [15:0] data,
  output logic        int_n,
  input  logic        rx_push_valid,
  input  logic [15:0] rx_push_data,
  output logic        rx_push_ready,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  input  logic        peer_connect,
  output logic        proto_err
);
  localparam int unsigned RxAw = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned TxAw = $clog2(TX_FIFO_DEPTH);
  localparam logic [RxAw:0] RxOne = 1;
  localparam logic [TxAw:0] TxOne = 1;
  localparam logic [7:0] CmdOpen = 8'h01, CmdListen = 8'h02, CmdClose = 8'h10;
  localparam logic [7:0] CmdSend = 8'h20, CmdRecv = 8'h40;

  typedef enum logic [2:0] {StClosed, StInit, StListen, StEstab, StSending} state_e;

  logic [1:0]  r_cs_s, r_rd_s, r_wr_s, r_wrst_s;
  logic        w_srst, w_wr_act, w_rd_act, r_wr_act_q, r_rd_act_q, w_wr_commit, w_rd_fall;
  logic [8:0]  r_waddr, r_raddr;
  logic [15:0] r_wdata, r_rd_q, w_rd_mux;
  logic [15:0] r_common [32];
  logic [15:0] r_sn_mr, r_sn_portr;
  logic [7:0]  r_sn_cr, r_sn_imr, r_sn_ir, w_ir_set, w_ir_clr, w_ssr;
  logic [16:0] r_tx_wrsr, r_send_cnt, w_send_words, w_tx_fsr, w_rx_rsr;
  logic [31:0] w_tx_free;
  state_e      r_state, w_state_d;
  logic        w_cr_clr, w_flush, w_send_start, w_send_done, w_set_con, w_send_end, w_ir0;
  logic        r_int_n, w_unused;
  logic [15:0] r_tx_mem [TX_FIFO_DEPTH];
  logic [15:0] r_rx_mem [RX_FIFO_DEPTH];
  logic [TxAw:0] r_tx_wp, r_tx_rp, w_tx_fill;
  logic [RxAw:0] r_rx_wp, r_rx_rp, w_rx_fill;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_tx_push_req, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;

  assign w_unused = ^{addr[0], CLK_FREQ};

  // Two-flop synchronizers for the host strobes and the host chip reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_s   <= 2'b11;
      r_rd_s   <= 2'b11;
      r_wr_s   <= 2'b11;
      r_wrst_s <= 2'b00;
    end else begin
      r_cs_s   <= {r_cs_s[0], cs_n};
      r_rd_s   <= {r_rd_s[0], rd_n};
      r_wr_s   <= {r_wr_s[0], wr_n};
      r_wrst_s <= {r_wrst_s[0], w_rst_n};
    end
  end

  assign w_srst      = ~r_wrst_s[1];
  assign w_wr_act    = ~r_cs_s[1] & ~r_wr_s[1];
  assign w_rd_act    = ~r_cs_s[1] & ~r_rd_s[1];
  assign w_wr_commit = r_wr_act_q & ~w_wr_act;
  assign w_rd_fall   = r_rd_act_q & ~w_rd_act;

  // Strobe edge detection; addr/data captured while the strobe is active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_act_q <= 1'b0;
      r_rd_act_q <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_raddr    <= '0;
    end else begin
      r_wr_act_q <= w_wr_act & ~w_srst;
      r_rd_act_q <= w_rd_act & ~w_srst;
      if (w_wr_act) begin
        r_waddr <= addr[9:1];
        r_wdata <= data;
      end
      if (w_rd_act) r_raddr <= addr[9:1];
    end
  end

  // FIFO status
  assign w_tx_fill     = r_tx_wp - r_tx_rp;
  assign w_rx_fill     = r_rx_wp - r_rx_rp;
  assign w_tx_full     = (w_tx_fill == (TxAw + 1)'(TX_FIFO_DEPTH));
  assign w_rx_full     = (w_rx_fill == (RxAw + 1)'(RX_FIFO_DEPTH));
  assign w_tx_empty    = (r_tx_wp == r_tx_rp);
  assign w_rx_empty    = (r_rx_wp == r_rx_rp);
  assign w_tx_free     = TX_FIFO_DEPTH - 32'(w_tx_fill);
  assign w_tx_fsr      = 17'(w_tx_free << 1);
  assign w_rx_rsr      = 17'({w_rx_fill, 1'b0});
  assign w_tx_push_req = w_wr_commit & ({r_waddr, 1'b0} == 10'h22E);
  assign w_tx_push     = w_tx_push_req & ~w_tx_full;
  assign w_tx_pop      = tx_valid & tx_ready;
  assign w_rx_push     = rx_push_valid & ~w_rx_full;
  assign w_rx_pop      = w_rd_fall & ({r_raddr, 1'b0} == 10'h230) & ~w_rx_empty;
  assign rx_push_ready = ~w_rx_full;
  assign tx_data       = r_tx_mem[r_tx_rp[TxAw-1:0]];

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[TxAw-1:0]] <= r_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wp[RxAw-1:0]] <= rx_push_data;
  end

  // FIFO pointers; CLOSE flushes both FIFOs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_rx_wp <= '0; r_rx_rp <= '0;
    end else if (w_srst || w_flush) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_rx_wp <= '0; r_rx_rp <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + TxOne;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + TxOne;
      if (w_rx_push) r_rx_wp <= r_rx_wp + RxOne;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + RxOne;
    end
  end

  assign w_ir_set = {3'b000, w_send_done, 3'b000, w_set_con};
  assign w_ir_clr = (w_wr_commit && {r_waddr, 1'b0} == 10'h206) ? r_wdata[7:0] : 8'h00;

  // Host register writes, Sn_CR command latch and Sn_IR set/W1C (set wins)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_common[i] <= (i == 0) ? 16'h3800 : 16'h0000;
      r_sn_mr <= '0; r_sn_portr <= '0; r_sn_cr <= '0; r_sn_imr <= '0; r_sn_ir <= '0;
      r_tx_wrsr <= '0;
    end else if (w_srst) begin
      for (int i = 0; i < 32; i++) r_common[i] <= (i == 0) ? 16'h3800 : 16'h0000;
      r_sn_mr <= '0; r_sn_portr <= '0; r_sn_cr <= '0; r_sn_imr <= '0; r_sn_ir <= '0;
      r_tx_wrsr <= '0;
    end else begin
      if (w_wr_commit && r_waddr[8:5] == 4'd0 && r_waddr[4:0] != 5'd1) begin
        r_common[r_waddr[4:0]] <= r_wdata;
      end
      if (w_wr_commit) begin
        case ({r_waddr, 1'b0})
          10'h200: r_sn_mr          <= r_wdata;
          10'h204: r_sn_imr         <= r_wdata[7:0];
          10'h20A: r_sn_portr       <= r_wdata;
          10'h220: r_tx_wrsr[16]    <= r_wdata[0];
          10'h222: r_tx_wrsr[15:0]  <= r_wdata;
          default: ;
        endcase
      end
      if (w_send_done) r_tx_wrsr <= '0;
      // While SENDING only CLOSE may replace the held SEND code
      if (w_wr_commit && {r_waddr, 1'b0} == 10'h202 &&
          (r_state != StSending || r_wdata[7:0] == CmdClose)) begin
        r_sn_cr <= r_wdata[7:0];
      end else if (w_cr_clr) begin
        r_sn_cr <= 8'h00;
      end
      r_sn_ir <= (r_sn_ir & ~w_ir_clr) | w_ir_set;
    end
  end

  assign w_send_words = 17'(({1'b0, r_tx_wrsr} + 18'd1) >> 1);
  assign w_send_end   = (r_send_cnt == 17'd0) || w_tx_empty;
  assign tx_valid     = (r_state == StSending) && !w_send_end;

  // Socket state register and SEND word counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StClosed;
      r_send_cnt <= '0;
    end else if (w_srst) begin
      r_state    <= StClosed;
      r_send_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_send_start)  r_send_cnt <= w_send_words;
      else if (w_tx_pop) r_send_cnt <= r_send_cnt - 17'd1;
    end
  end

  // Command decode, peer connect and SENDING completion
  always_comb begin
    w_state_d    = r_state;
    w_cr_clr     = 1'b0;
    w_flush      = 1'b0;
    w_send_start = 1'b0;
    w_send_done  = 1'b0;
    w_set_con    = 1'b0;
    if (r_sn_cr == CmdClose) begin
      w_state_d = StClosed;
      w_cr_clr  = 1'b1;
      w_flush   = 1'b1;
    end else if (r_state == StSending) begin
      if (w_send_end) begin
        w_state_d   = StEstab;
        w_cr_clr    = 1'b1;
        w_send_done = 1'b1;
      end
    end else if (r_state == StListen && peer_connect) begin
      w_state_d = StEstab;
      w_set_con = 1'b1;
    end else if (r_sn_cr != 8'h00) begin
      w_cr_clr = 1'b1;
      case (r_sn_cr)
        CmdOpen:   if (r_state == StClosed && r_sn_mr[3:0] == 4'h1) w_state_d = StInit;
        CmdListen: if (r_state == StInit) w_state_d = StListen;
        CmdSend: begin
          if (r_state == StEstab) begin
            w_state_d    = StSending;
            w_cr_clr     = 1'b0;
            w_send_start = 1'b1;
          end
        end
        CmdRecv:   ;
        default:   ;
      endcase
    end
  end

  // SSR encoding; SENDING still reports ESTABLISHED
  always_comb begin
    w_ssr = 8'h00;
    case (r_state)
      StInit:             w_ssr = 8'h13;
      StListen:           w_ssr = 8'h14;
      StEstab, StSending: w_ssr = 8'h17;
      default:            w_ssr = 8'h00;
    endcase
  end

  assign w_ir0 = |(r_sn_ir & r_sn_imr);

  // Read mux at the live address
  always_comb begin
    w_rd_mux = 16'h0000;
    if (addr[9:6] == 4'd0) begin
      w_rd_mux = (addr[5:1] == 5'd1) ? {15'd0, w_ir0} : r_common[addr[5:1]];
    end else begin
      case ({addr[9:1], 1'b0})
        10'h0FE: w_rd_mux = CHIP_ID;
        10'h200: w_rd_mux = r_sn_mr;
        10'h202: w_rd_mux = {8'h00, r_sn_cr};
        10'h204: w_rd_mux = {8'h00, r_sn_imr};
        10'h206: w_rd_mux = {8'h00, r_sn_ir};
        10'h208: w_rd_mux = {8'h00, w_ssr};
        10'h20A: w_rd_mux = r_sn_portr;
        10'h220: w_rd_mux = {15'd0, r_tx_wrsr[16]};
        10'h222: w_rd_mux = r_tx_wrsr[15:0];
        10'h224: w_rd_mux = {15'd0, w_tx_fsr[16]};
        10'h226: w_rd_mux = w_tx_fsr[15:0];
        10'h228: w_rd_mux = {15'd0, w_rx_rsr[16]};
        10'h22A: w_rd_mux = w_rx_rsr[15:0];
        10'h230: w_rd_mux = w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rp[RxAw-1:0]];
        default: w_rd_mux = 16'h0000;
      endcase
    end
  end

  // Registered read data and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_q  <= '0;
      r_int_n <= 1'b1;
    end else if (w_srst) begin
      r_rd_q  <= '0;
      r_int_n <= 1'b1;
    end else begin
      r_rd_q  <= w_rd_mux;
      r_int_n <= ~w_ir0;
    end
  end

  assign int_n = r_int_n;
  // Bus driven from the raw strobes so release is immediate
  assign data  = (!cs_n && !rd_n) ? r_rd_q : 16'hzzzz;

`ifdef W5300_RESP_PROTO_CHECK_EN
  logic [2:0] r_strb_cnt;
  logic       r_proto_err, w_any_act, w_any_fall;
  assign w_any_act  = w_wr_act | w_rd_act;
  assign w_any_fall = (r_wr_act_q | r_rd_act_q) & ~w_any_act;

  // Sticky protocol error: rd/wr overlap, strobe shorter than 4 clk, push into full TX FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strb_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else if (w_srst) begin
      r_strb_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_any_act) r_strb_cnt <= (r_strb_cnt == 3'd7) ? r_strb_cnt : r_strb_cnt + 3'd1;
      else           r_strb_cnt <= 3'd0;
      if ((w_wr_act && w_rd_act) || (w_any_fall && r_strb_cnt < 3'd4) ||
          (w_tx_push_req && w_tx_full)) begin
        r_proto_err <= 1'b1;
      end
    end
  end
  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: doc/w5300_bus_responder.md
# w5300_bus_responder

Synthesizable responder model of the W5300 16-bit direct-mode host bus: answers `cs_n`/`rd_n`/`wr_n`/`addr`/`data` accesses with a common register file, a socket-0 register set and socket-0 TX/RX data FIFOs. It sits on the opposite end of the pins driven by `w5300_interface`. It serves as the chip stand-in for loopback builds and the driver bench. Test-side streams inject received payload and drain transmitted payload.

## Interface
- `CLK_FREQ`, 8'd100: clock in MHz. Informational only; the responder itself is clock-agnostic.
- `RX_FIFO_DEPTH`, 64: RX FIFO depth in 16-bit words. Must be a power of two.
- `TX_FIFO_DEPTH`, 64: TX FIFO depth in 16-bit words. Must be a power of two.
- `CHIP_ID`, 16'h5300: value returned by IDR at 0x0FE.

- `clk` input 1: single clock.
- `rst` input 1: asynchronous, active-high reset.
- `w_rst_n` input 1: chip reset from the host. Synchronized; while low, the block behaves as under `rst`.
- `cs_n`, `rd_n`, `wr_n` input 1 each: host strobes, asynchronous to `clk`.
- `addr` input 10: byte address. Bit 0 is ignored.
- `data` inout tri 16: driven only while raw `cs_n`=0 and `rd_n`=0; otherwise Z.
- `int_n` output 1: interrupt, active low.
- `rx_push_valid` input 1, `rx_push_data` input 16, `rx_push_ready` output 1: payload into the RX FIFO.
- `tx_valid` output 1, `tx_data` output 16, `tx_ready` input 1: payload out of the TX FIFO during SEND.
- `peer_connect` input 1: one-cycle pulse emulating a remote TCP SYN.
- `proto_err` output 1: sticky bus-protocol error flag.

## Operation
- **Strobe handling**
  - `cs_n`, `rd_n`, `wr_n` and `w_rst_n` each pass through a 2-flop synchronizer.
  - `wr_act` = synchronized cs low AND synchronized wr low. `rd_act` is defined the same way with rd.
  - `addr` and `data` are captured every cycle while `wr_act`=1.
- **Write**: commits on the falling edge of `wr_act` using the last captured addr/data.
- **Read**
  - `rd_q` is registered every cycle from the read mux at the current `addr`, and drives `data`.
  - Side effects (FIFO pop) occur on the falling edge of `rd_act`.
- **Common registers**: 0x000–0x03E form a 32-word R/W file. MR at 0x000 resets to 16'h3800; all others reset to 0.
  - IR at 0x002 is read-only. IR[0] = |(Sn_IR & Sn_IMR).
  - IMR is at 0x004.
  - IDR at 0x0FE reads `CHIP_ID`.
  - Any other unmapped address reads 0 and ignores writes.
- **Socket 0 registers**
  - Sn_MR 0x200 (R/W).
  - Sn_CR 0x202.
  - Sn_IMR 0x204 (R/W).
  - Sn_IR 0x206: write-1-to-clear.
  - Sn_SSR 0x208 (RO).
  - Sn_PORTR 0x20A (R/W).
  - Sn_TX_WRSR 0x220/0x222 (R/W, 17-bit byte count).
  - Sn_TX_FSR 0x224/0x226 (RO) = 2×(TX_FIFO_DEPTH − fill).
  - Sn_RX_RSR 0x228/0x22A (RO) = 2×RX fill.
  - Sn_TX_FIFOR 0x22E (WO, push).
  - Sn_RX_FIFOR 0x230 (RO, pop).
- **Command FSM**, states CLOSED(SSR 0x00), INIT(0x13), LISTEN(0x14), ESTAB(0x17), SENDING.
  - OPEN (0x01) with Sn_MR[3:0]=1: CLOSED → INIT.
  - LISTEN (0x02): INIT → LISTEN.
  - `peer_connect` in LISTEN: LISTEN → ESTAB and sets Sn_IR[0] (CON).
  - CLOSE (0x10): from any state → CLOSED; flushes both FIFOs.
  - SEND (0x20) in ESTAB: enters SENDING.
    - Pops ceil(TX_WRSR/2) words on `tx_valid` & `tx_ready`; stops early if the TX FIFO empties.
    - Then returns to ESTAB, sets Sn_IR[4] (SENDOK) and clears TX_WRSR.
  - RECV (0x40): no-op acknowledge.
  - Illegal or out-of-state commands: ignored.
- **Boundaries**
  - TX FIFO push when full: word dropped.
  - RX FIFO pop when empty: reads 16'h0000, pointers unchanged.
  - `rx_push_ready` = RX FIFO not full.
  - An event setting an Sn_IR bit in the same cycle a W1C clears it: set wins.

## Timing
- **Reset values**: `data`=Z, `int_n`=1, `tx_valid`=0, `proto_err`=0, `rx_push_ready`=1, SSR=0x00.
- **Write latency**: a write commits 3 clk after the wr_n rising edge (2 sync + edge detect).
- **Host hold times**:
  - The host must hold rd_n/wr_n low for ≥4 clk.
  - The host must keep ≥3 clk between strobes.
- **Read data**: `data` is valid 1 clk after `addr` is stable while the strobe is low.
- **Sn_CR**
  - Reads the command value for exactly 1 clk after commit, then 0x00.
  - Exception: SEND keeps 0x20 until SENDING exits.
- **State/interrupt update**: SSR updates in the cycle Sn_CR clears. `int_n` is registered and follows the IR change by 1 clk.
- **Reset mid-operation**: `rst` or `w_rst_n` during SENDING aborts it immediately. `tx_valid` drops and nothing is flagged.

## Configuration
- **`W5300_RESP_PROTO_CHECK_EN` defined**: `proto_err` sets and stays set until reset when any of the following occurs:
  - synchronized rd and wr are low simultaneously under cs;
  - a strobe is held for fewer than 4 clk;
  - a TX FIFO push is made while full.
- **Undefined**: `proto_err` is tied 0 and the checker logic is absent.

## Test plan
- After reset, read 0x0FE → 16'h5300. Read 0x000 → 16'h3800. `int_n`=1.
- Write Sn_MR=0x0001, CR=0x01, then CR=0x02, then pulse `peer_connect` with Sn_IMR=0x01.
  - SSR reads 0x13 after OPEN, 0x14 after LISTEN and 0x17 after the pulse.
  - `int_n` goes low.
  - Writing Sn_IR=0x01 returns `int_n` to 1.
- Push 3 words 0xA1A2, 0xB1B2, 0xC1C2 via `rx_push`.
  - RX_RSR reads 6.
  - Three reads of 0x230 return them in order; a fourth read returns 0.
- In ESTAB, write 4 words to 0x22E, set TX_WRSR=7, issue SEND with `tx_ready` toggling.
  - Exactly 4 words appear on `tx_data`.
  - Sn_IR[4] is set and CR reads 0.
- Fill the TX FIFO to depth plus 1 extra write.
  - TX_FSR reads 0.
  - The extra word is dropped.
  - With the macro defined, `proto_err`=1.
- Assert `w_rst_n`=0 mid-SEND: `tx_valid` drops within 3 clk and SSR=0x00.
